// File: rtl/cla_pkg.sv
// Purpose: shared types and helpers for the multi-word sequential CLA adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cla_pkg;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Word-counter width: must be able to hold WORDS-1, plus one spare bit.
    function automatic int cla_cw(input int words);
        return $clog2(words) + 1;
    endfunction

endpackage

// File: rtl/cla_mw_seq_if.sv
// Purpose: operand/result handshake bundle for cla_mw_seq.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
// Signals: in_valid, in_ready, a, b, cin (operand side); out_valid, out_ready, sum, cout, ovf (result side); busy (status).
interface cla_mw_seq_if #(
    parameter int ASIZE = 4,
    parameter int WORDS = 4
);
    localparam int W = ASIZE * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/cla_word_add.sv
// Purpose: combinational one-word carry-look-ahead adder slice.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b (ASIZE-bit operands), cin -> s (ASIZE-bit sum), cout, c_msb_in (carry into top bit).
module cla_word_add #(
    parameter int ASIZE = 4
) (
    input  logic [ASIZE-1:0] a,
    input  logic [ASIZE-1:0] b,
    input  logic             cin,
    output logic [ASIZE-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);
    logic [ASIZE-1:0] w_p;
    logic [ASIZE-1:0] w_g;
    // w_c[i] is the carry into bit i; w_c[0] is the slice carry-in.
    logic [ASIZE:0]   w_c;

    assign w_p    = a ^ b;
    assign w_g    = a & b;
    assign w_c[0] = cin;

    for (genvar i = 0; i < ASIZE; i++) begin : g_bit
        assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        assign s[i]     = w_p[i] ^ w_c[i];
    end

    assign cout     = w_c[ASIZE];
    assign c_msb_in = w_c[ASIZE-1];
endmodule

// File: rtl/cla_mw_seq.sv
// Purpose: WORDS*ASIZE-bit adder built from one ASIZE-bit CLA slice, one word per cycle, LSW first.
// Latency: out_valid rises WORDS cycles after the accept edge.
// Backpressure: result held stable in DONE until out_ready; in_ready low whenever not IDLE.
// Ports: clk, rst_n (sync, active low); bus = cla_mw_seq_if.slave (operands in, result out, busy).
module cla_mw_seq
    import cla_pkg::*;
#(
    parameter int ASIZE = 4,
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    cla_mw_seq_if.slave   bus
);
    localparam int W  = ASIZE * WORDS;
    localparam int CW = cla_cw(WORDS);

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_a_sh;
    logic [W-1:0]    r_b_sh;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_cout;
    logic            r_ovf;
    logic            r_out_valid;
    logic [CW-1:0]   r_cnt;

    logic [ASIZE-1:0] w_s;
    logic             w_slice_cout;
    logic             w_slice_cmsb;
    logic             w_accept;
    logic             w_deliver;
    logic             w_last;

    cla_word_add #(.ASIZE(ASIZE)) u_slice (
        .a        (r_a_sh[ASIZE-1:0]),
        .b        (r_b_sh[ASIZE-1:0]),
        .cin      (r_carry),
        .s        (w_s),
        .cout     (w_slice_cout),
        .c_msb_in (w_slice_cmsb)
    );

    assign w_accept  = bus.in_valid && (r_state == IDLE);
    assign w_deliver = r_out_valid && bus.out_ready;
    assign w_last    = (r_cnt == CW'(WORDS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (w_deliver) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Datapath: operand shift registers, carry chain register, result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (r_cnt == CW'(k)) r_sum[k*ASIZE +: ASIZE] <= w_s;
                    end
                    r_carry <= w_slice_cout;
                    r_a_sh  <= r_a_sh >> ASIZE;
                    r_b_sh  <= r_b_sh >> ASIZE;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Top word: its flags describe the whole W-bit add.
                        r_cout      <= w_slice_cout;
                        r_ovf       <= w_slice_cout ^ w_slice_cmsb;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (w_deliver) r_out_valid <= 1'b0;
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_cla_mw_seq.sv
// Purpose: directed self-checking bench for cla_mw_seq (WORDS=4 and WORDS=1 builds).
// Latency: checks result appears exactly WORDS cycles after accept.
// Backpressure: exercises out_ready held low in DONE and in_valid held high during RUN.
module tb_cla_mw_seq;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    cla_mw_seq_if #(.ASIZE(4), .WORDS(4)) bus4 ();
    cla_mw_seq_if #(.ASIZE(4), .WORDS(1)) bus1 ();

    cla_mw_seq #(.ASIZE(4), .WORDS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    cla_mw_seq #(.ASIZE(4), .WORDS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid on the 4-word DUT; lat counts edges after the accept edge.
    task automatic wait4(output int lat);
        lat = 0;
        while (!bus4.out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic wait1(output int lat);
        lat = 0;
        while (!bus1.out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    // Accept one operand set on the 4-word DUT, wait for it, check, then drain.
    task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [15:0] e_sum, input logic e_cout,
                       input logic e_ovf);
        int lat;
        chk({tag, "_in_ready"}, 32'(bus4.in_ready), 32'd1);
        bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.in_valid = 1'b1;
        step();
        bus4.in_valid = 1'b0;
        bus4.a = 16'h5A5A; bus4.b = 16'hA5A5; bus4.cin = ~cin;
        wait4(lat);
        chk({tag, "_lat"},  32'(lat), 32'd4);
        chk({tag, "_sum"},  32'(bus4.sum), 32'(e_sum));
        chk({tag, "_cout"}, 32'(bus4.cout), 32'(e_cout));
        chk({tag, "_ovf"},  32'(bus4.ovf), 32'(e_ovf));
        bus4.out_ready = 1'b1;
        step();
        bus4.out_ready = 1'b0;
        chk({tag, "_drain"}, 32'(bus4.out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [15:0] snap_sum;
        logic        snap_cout;
        logic        snap_ovf;

        rst_n = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst_sum",       32'(bus4.sum), 32'd0);
        chk("rst_cout",      32'(bus4.cout), 32'd0);
        chk("rst_ovf",       32'(bus4.ovf), 32'd0);
        chk("rst_busy",      32'(bus4.busy), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready",  32'(bus4.in_ready), 32'd1);

        // Main arithmetic vectors.
        op4("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op4("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        op4("1234_4321_c", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        op4("8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Back-pressure: result held for 5 cycles with out_ready low.
        bus4.a = 16'h00FF; bus4.b = 16'h0F01; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
        step();
        bus4.in_valid = 1'b0;
        wait4(lat);
        chk("bp_lat", 32'(lat), 32'd4);
        chk("bp_sum", 32'(bus4.sum), 32'h1000);
        snap_sum = bus4.sum; snap_cout = bus4.cout; snap_ovf = bus4.ovf;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 32'(bus4.out_valid), 32'd1);
            chk("bp_hold_sum",   32'(bus4.sum), 32'(snap_sum));
            chk("bp_hold_flags", 32'({bus4.cout, bus4.ovf}), 32'({snap_cout, snap_ovf}));
            chk("bp_in_ready",   32'(bus4.in_ready), 32'd0);
        end
        bus4.out_ready = 1'b1;
        step();
        bus4.out_ready = 1'b0;
        chk("bp_release_valid", 32'(bus4.out_valid), 32'd0);
        chk("bp_release_ready", 32'(bus4.in_ready), 32'd1);

        // in_valid held high across RUN/DONE with changing operands.
        bus4.a = 16'h1234; bus4.b = 16'h4321; bus4.cin = 1'b1; bus4.in_valid = 1'b1;
        step();
        bus4.a = 16'hAAAA; bus4.b = 16'h1111; bus4.cin = 1'b0;
        wait4(lat);
        chk("hold_lat",  32'(lat), 32'd4);
        chk("hold_sum1", 32'(bus4.sum), 32'h5556);
        chk("hold_busy", 32'(bus4.busy), 32'd1);
        bus4.out_ready = 1'b1;
        step();
        bus4.out_ready = 1'b0;
        chk("hold_idle_ready", 32'(bus4.in_ready), 32'd1);
        step();
        bus4.in_valid = 1'b0;
        wait4(lat);
        chk("hold_lat2",  32'(lat), 32'd4);
        chk("hold_sum2",  32'(bus4.sum), 32'hBBBB);
        chk("hold_flags2", 32'({bus4.cout, bus4.ovf}), 32'd0);
        bus4.out_ready = 1'b1;
        step();
        bus4.out_ready = 1'b0;

        // Reset at the second RUN cycle aborts the operation.
        bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
        step();
        bus4.in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("abort_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("abort_sum",       32'(bus4.sum), 32'd0);
        chk("abort_busy",      32'(bus4.busy), 32'd0);
        chk("abort_in_ready",  32'(bus4.in_ready), 32'd1);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus4.out_valid) pulses++;
        end
        chk("abort_no_pulse", 32'(pulses), 32'd0);

        // Single-word build: 1-cycle latency.
        bus1.a = 4'hF; bus1.b = 4'h1; bus1.cin = 1'b1; bus1.in_valid = 1'b1;
        step();
        bus1.in_valid = 1'b0;
        wait1(lat);
        chk("w1_lat",  32'(lat), 32'd1);
        chk("w1_sum",  32'(bus1.sum), 32'h1);
        chk("w1_cout", 32'(bus1.cout), 32'd1);
        chk("w1_ovf",  32'(bus1.ovf), 32'd0);
        bus1.out_ready = 1'b1;
        step();
        bus1.out_ready = 1'b0;
        chk("w1_drain", 32'(bus1.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
